// File: rtl/iprog_loader_pkg.sv
// Shared types and default constants for the serial instruction-memory loader.
package iprog_loader_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 139;
  localparam logic [7:0]  DEF_SYNC_BYTE    = 8'hA5;

  typedef enum logic [2:0] {
    SYNC,
    COUNT,
    WORD_HI,
    WORD_LO,
    CHECK,
    DONE
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/iprog_loader_if.sv
// Instruction-memory write port driven by the loader (master) into the memory (slave).
interface iprog_loader_if;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/iprog_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, byte_valid / frame_err pulses.
module uart_rx_byte
  import iprog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          rx_meta, rx_s, rx_q;
  logic          valid_n, err_n;

  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_q       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_q       <= rx_s;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_q && !rx_s) state_n = RX_START;
      end
      RX_START: begin
        // Half-bit re-check rejects glitches; later samples land mid-bit.
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          valid_n = rx_s;
          err_n   = !rx_s;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign data = shreg;

endmodule

// File: rtl/iprog_loader.sv
// Serial program loader: frames UART bytes into 16-bit words written from address 0 and
// holds the CPU in reset until a load completes. Optional CHK byte: `define LOADER_CHECKSUM_EN.
module iprog_loader
  import iprog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           rx,
  iprog_loader_if.master imem,
  output logic           cpu_hold,
  output logic           load_done,
  output logic           load_err
);

  logic [7:0]  rx_data;
  logic        byte_valid, frame_err, start_load;

  load_state_t state, state_n;
  logic [7:0]  addr, addr_n, hi, hi_n;
  logic [8:0]  left, left_n;
  logic        we_q, we_n;
  logic [7:0]  waddr, waddr_n;
  logic [15:0] wdata, wdata_n;
  logic        hold_n, done_n, err_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  acc, acc_n;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK        (CLK),
    .reset      (reset),
    .rx         (rx),
    .data       (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign start_load = byte_valid && (rx_data == SYNC_BYTE);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= SYNC;
      addr      <= '0;
      hi        <= '0;
      left      <= '0;
      we_q      <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      hi        <= hi_n;
      left      <= left_n;
      we_q      <= we_n;
      waddr     <= waddr_n;
      wdata     <= wdata_n;
      cpu_hold  <= hold_n;
      load_done <= done_n;
      load_err  <= err_n;
`ifdef LOADER_CHECKSUM_EN
      acc       <= acc_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    hi_n    = hi;
    left_n  = left;
    we_n    = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;
    hold_n  = cpu_hold;
    done_n  = load_done;
    err_n   = load_err;
`ifdef LOADER_CHECKSUM_EN
    acc_n   = acc;
`endif
    if (frame_err && (state inside {COUNT, WORD_HI, WORD_LO, CHECK})) begin
      err_n   = 1'b1;
      state_n = SYNC;
    end else if (start_load && (state == SYNC || state == DONE)) begin
      err_n   = 1'b0;
      done_n  = 1'b0;
      hold_n  = 1'b1;
      addr_n  = '0;
      state_n = COUNT;
`ifdef LOADER_CHECKSUM_EN
      acc_n   = '0;
`endif
    end else if (byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
      if (state inside {COUNT, WORD_HI, WORD_LO}) acc_n = acc ^ rx_data;
`endif
      case (state)
        COUNT: begin
          left_n  = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          state_n = WORD_HI;
        end
        WORD_HI: begin
          hi_n    = rx_data;
          state_n = WORD_LO;
        end
        WORD_LO: begin
          we_n    = 1'b1;
          waddr_n = addr;
          wdata_n = {hi, rx_data};
          addr_n  = addr + 1'b1;
          left_n  = left - 1'b1;
`ifdef LOADER_CHECKSUM_EN
          state_n = (left == 9'd1) ? CHECK : WORD_HI;
`else
          state_n = (left == 9'd1) ? DONE : WORD_HI;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_data == acc) begin
            state_n = DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            err_n   = 1'b1;
            state_n = SYNC;
          end
        end
`endif
        default: ;
      endcase
    end
    // Settled DONE releases the CPU; without a CHK byte this lands one cycle after the last write.
    if (state == DONE && state_n == DONE) begin
      done_n = 1'b1;
      hold_n = 1'b0;
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = waddr;
  assign imem.imem_wdata = wdata;

endmodule

// File: tb/tb_iprog_loader.sv
// Self-checking bench for iprog_loader: UART byte driver, write monitor and frame-level reference model.
module tb_iprog_loader;

  localparam int unsigned CPB = 8;
  localparam logic [7:0]  SB  = 8'hA5;

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic cpu_hold, load_done, load_err;

  iprog_loader_if imem_bus();

  iprog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SB)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .rx        (rx),
    .imem      (imem_bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;

  int          vectors     = 0;
  int          miscompares = 0;
  wr_t         got[$];
  wr_t         exp_w[$];
  logic [7:0]  tx[$];
  logic        exp_done, exp_hold, exp_err;
  int unsigned cyc = 0, last_we_cyc = 0, done_rise_cyc = 0, stop_cyc = 0;
  logic        done_prev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (imem_bus.imem_we === 1'b1) begin
      got.push_back('{imem_bus.imem_addr, imem_bus.imem_wdata});
      last_we_cyc = cyc;
    end
    if (load_done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = load_done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: the frame the bench intends to send and the outcome it must produce.
  task automatic build_frame(input logic [15:0] w[$], input bit bad_chk);
    logic [7:0] chk;
    chk = 8'(w.size());
    tx.push_back(SB);
    tx.push_back(8'(w.size()));
    exp_w.delete();
    foreach (w[i]) begin
      tx.push_back(w[i][15:8]);
      tx.push_back(w[i][7:0]);
      chk = chk ^ w[i][15:8] ^ w[i][7:0];
      exp_w.push_back('{8'(i), w[i]});
    end
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(bad_chk ? ((chk != 8'h00) ? 8'h00 : 8'hFF) : chk);
    exp_err  = bad_chk;
    exp_hold = bad_chk;
    exp_done = !bad_chk;
`else
    if (bad_chk) tx.push_back(8'h00);
    exp_err  = 1'b0;
    exp_hold = 1'b0;
    exp_done = 1'b1;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(posedge CLK);
    rx = 1'b0;
    repeat (CPB) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge CLK);
    end
    rx = stop;
    stop_cyc = cyc;
    repeat (CPB) @(posedge CLK);
    rx = 1'b1;
    repeat ($urandom_range(0, 3)) @(posedge CLK);
  endtask

  task automatic send_tx();
    while (tx.size() > 0) send_byte(tx.pop_front(), 1'b1);
    repeat (4 * CPB) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    @(posedge CLK);
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (imem_bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", imem_bus.imem_we); end
    vectors++; if (imem_bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h expected 00", imem_bus.imem_addr); end
    vectors++; if (imem_bus.imem_wdata !== 16'h0000) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0000", imem_bus.imem_wdata); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", load_done); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", load_err); end
  endtask

  task automatic test_known_frame();
    logic [15:0] w[$];
    w = '{16'h1234, 16'hABCD};
    for (int pass = 0; pass < 2; pass++) begin
      got.delete();
      build_frame(w, pass == 1);
      send_tx();
      vectors++;
      if (got.size() != exp_w.size()) begin miscompares++; $display("FAIL known_count[%0d]: got %0d writes expected %0d", pass, got.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
        vectors++;
        if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL known_write[%0d.%0d]: got %h:%h expected %h:%h", pass, i, got[i].a, got[i].d, exp_w[i].a, exp_w[i].d); end
      end
      vectors++; if (load_done !== exp_done) begin miscompares++; $display("FAIL known_done[%0d]: got %b expected %b", pass, load_done, exp_done); end
      vectors++; if (cpu_hold !== exp_hold) begin miscompares++; $display("FAIL known_hold[%0d]: got %b expected %b", pass, cpu_hold, exp_hold); end
      vectors++; if (load_err !== exp_err) begin miscompares++; $display("FAIL known_err[%0d]: got %b expected %b", pass, load_err, exp_err); end
      if (pass == 0) begin
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (done_rise_cyc <= stop_cyc || done_rise_cyc > stop_cyc + CPB + 4) begin
          miscompares++; $display("FAIL known_done_timing: rose at cycle %0d, expected within (%0d,%0d]", done_rise_cyc, stop_cyc, stop_cyc + CPB + 4);
        end
`else
        vectors++;
        if (done_rise_cyc != last_we_cyc + 1) begin
          miscompares++; $display("FAIL known_done_timing: rose at cycle %0d expected %0d", done_rise_cyc, last_we_cyc + 1);
        end
`endif
      end
    end
  endtask

  task automatic test_leading_garbage();
    logic [15:0] w[$];
    got.delete();
    @(posedge CLK);
    rx = 1'b0;
    repeat (2) @(posedge CLK);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    w = '{16'h0007};
    build_frame(w, 1'b0);
    send_tx();
    vectors++; if (got.size() != 1) begin miscompares++; $display("FAIL garbage_count: got %0d writes expected 1", got.size()); end
    if (got.size() > 0) begin
      vectors++; if (got[0] !== exp_w[0]) begin miscompares++; $display("FAIL garbage_write: got %h:%h expected %h:%h", got[0].a, got[0].d, exp_w[0].a, exp_w[0].d); end
    end
    vectors++; if (load_done !== exp_done) begin miscompares++; $display("FAIL garbage_done: got %b expected %b", load_done, exp_done); end
    vectors++; if (load_err !== exp_err) begin miscompares++; $display("FAIL garbage_err: got %b expected %b", load_err, exp_err); end
  endtask

  task automatic test_framing_error();
    got.delete();
    send_byte(SB, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (4 * CPB) @(posedge CLK);
    @(negedge CLK);
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL frame_err_flag: got %b expected 1", load_err); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL frame_err_hold: got %b expected 1", cpu_hold); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL frame_err_done: got %b expected 0", load_done); end
    // Back in SYNC: further data bytes must neither write nor clear the error.
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    repeat (4 * CPB) @(posedge CLK);
    @(negedge CLK);
    vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL frame_err_writes: got %0d writes expected 0", got.size()); end
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL frame_err_sticky: got %b expected 1", load_err); end
  endtask

  task automatic test_random_frames();
    logic [15:0] w[$];
    bit bad;
    for (int f = 0; f < 4; f++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) w.push_back(16'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      got.delete();
      build_frame(w, bad);
      send_tx();
      vectors++;
      if (got.size() != exp_w.size()) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d writes expected %0d", f, got.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
        vectors++;
        if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL rand_write[%0d.%0d]: got %h:%h expected %h:%h", f, i, got[i].a, got[i].d, exp_w[i].a, exp_w[i].d); end
      end
      vectors++; if (load_done !== exp_done) begin miscompares++; $display("FAIL rand_done[%0d]: got %b expected %b", f, load_done, exp_done); end
      vectors++; if (cpu_hold !== exp_hold) begin miscompares++; $display("FAIL rand_hold[%0d]: got %b expected %b", f, cpu_hold, exp_hold); end
      vectors++; if (load_err !== exp_err) begin miscompares++; $display("FAIL rand_err[%0d]: got %b expected %b", f, load_err, exp_err); end
    end
  endtask

  task automatic test_full_count();
    logic [15:0] w[$];
    int bad_words = 0;
    for (int i = 0; i < 256; i++) w.push_back({8'(i) ^ 8'h5A, 8'(i)});
    got.delete();
    build_frame(w, 1'b0);
    send_tx();
    vectors++; if (got.size() != 256) begin miscompares++; $display("FAIL full_count: got %0d writes expected 256", got.size()); end
    for (int i = 0; i < 256 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        if (bad_words < 4) $display("FAIL full_write[%0d]: got %h:%h expected %h:%h", i, got[i].a, got[i].d, exp_w[i].a, exp_w[i].d);
        bad_words++;
      end
    end
    if (got.size() > 0) begin
      vectors++; if (got[got.size()-1].a !== 8'hFF) begin miscompares++; $display("FAIL full_last_addr: got %h expected ff", got[got.size()-1].a); end
    end
    vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL full_done: got %b expected 1", load_done); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL full_hold: got %b expected 0", cpu_hold); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w[$];
    w = '{16'($urandom), 16'($urandom), 16'($urandom)};
    got.delete();
    tx.delete();
    build_frame(w, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(tx.pop_front(), 1'b1);
    tx.delete();
    repeat (4 * CPB) @(posedge CLK);
    @(negedge CLK);
    vectors++; if (got.size() != 1) begin miscompares++; $display("FAIL midrst_pre_writes: got %0d expected 1", got.size()); end
    @(posedge CLK);
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++; if (imem_bus.imem_we !== 1'b0) begin miscompares++; $display("FAIL midrst_we: got %b expected 0", imem_bus.imem_we); end
    vectors++; if (imem_bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL midrst_addr: got %h expected 00", imem_bus.imem_addr); end
    vectors++; if (imem_bus.imem_wdata !== 16'h0000) begin miscompares++; $display("FAIL midrst_wdata: got %h expected 0000", imem_bus.imem_wdata); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL midrst_hold: got %b expected 1", cpu_hold); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b expected 0", load_done); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b expected 0", load_err); end
    reset = 1'b0;
    w = '{16'($urandom), 16'($urandom)};
    got.delete();
    build_frame(w, 1'b0);
    send_tx();
    vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL midrst_reload_count: got %0d writes expected 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL midrst_reload_write[%0d]: got %h:%h expected %h:%h", i, got[i].a, got[i].d, exp_w[i].a, exp_w[i].d); end
    end
    vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL midrst_reload_done: got %b expected 1", load_done); end
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_leading_garbage();
    test_framing_error();
    test_random_frames();
    test_full_count();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
